// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling default and
// frame-length limits. The transmitter uses the same package.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int NBITS_MIN      = 5;
  localparam int NBITS_MAX      = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_BREAK = 3'd4;

  // Out-of-range frame lengths fall back to the longest frame.
  function automatic logic [3:0] nbits_eff(input logic [3:0] nbits);
    if (nbits < 4'(NBITS_MIN) || nbits > 4'(NBITS_MAX))
      return 4'(NBITS_MAX);
    return nbits;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input pin; both flops reset
// to 1 so an idle-high line reads as idle straight out of reset.
module uart_sync2 (
  input  logic Clk,
  input  logic Rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_ff;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) sync_ff <= 2'b11;
    else        sync_ff <= {sync_ff[0], d};
  end

  assign q = sync_ff[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 5..8 data bits LSB first, 1 stop bit, no
// parity, sampled on a shared OVERSAMPLE x baud Tick strobe.
//
// state    | meaning
// IDLE     | line idle, waiting for a low sample
// START    | counting to mid start bit to reject glitches
// DATA     | sampling one data bit per bit period
// STOP     | sampling the stop bit at its midpoint
// BREAK    | stop bit was low; wait for the line to go high again
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_W     = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Tick,
  input  logic              Rx,
  input  logic [3:0]        NBits,
  output logic [DATA_W-1:0] RxData,
  output logic              RxDone,
  output logic              FrameErr,
  output logic              Busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);

  state_t              state;
  logic [TW-1:0]       tick_cnt;
  logic [3:0]          bit_cnt;
  logic [3:0]          nbits_q;
  logic [DATA_W-1:0]   shift;
  logic                rx_s;

  uart_sync2 u_sync (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .d     (Rx),
    .q     (rx_s)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      nbits_q  <= 4'(NBITS_MAX);
      shift    <= '0;
      RxData   <= '0;
      RxDone   <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      RxDone   <= 1'b0;
      FrameErr <= 1'b0;
      if (Tick) begin
        case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              state    <= ST_START;
              tick_cnt <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt == TC_HALF) begin
              if (!rx_s) begin
                state    <= ST_DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
                shift    <= '0;
                nbits_q  <= nbits_eff(NBits);
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_DATA: begin
            if (tick_cnt == TC_FULL) begin
              // shift is cleared on entry, so short frames come out zero-extended
              shift    <= shift | (DATA_W'(rx_s) << bit_cnt);
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == nbits_q - 4'd1) state <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_STOP: begin
            if (tick_cnt == TC_FULL) begin
              RxData   <= shift;
              tick_cnt <= '0;
              if (rx_s) begin
                RxDone <= 1'b1;
                state  <= ST_IDLE;
              end else begin
                FrameErr <= 1'b1;
                state    <= ST_BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_BREAK: begin
            if (rx_s) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit by bit, expected
// words are queued at send time and popped when the receiver reports.
module tb_uart_rx;

  logic       Clk   = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Tick  = 1'b0;
  logic       Rx    = 1'b1;
  logic [3:0] NBits = 4'd8;
  logic [7:0] RxData;
  logic       RxDone;
  logic       FrameErr;
  logic       Busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clocks

  uart_rx #(.OVERSAMPLE(16), .DATA_W(8)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Tick     (Tick),
    .Rx       (Rx),
    .NBits    (NBits),
    .RxData   (RxData),
    .RxDone   (RxDone),
    .FrameErr (FrameErr),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(negedge Clk);
      Tick = (div == 3);
      div  = (div + 1) % 4;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_bits(input int n);
    return (n < 5 || n > 8) ? 8 : n;
  endfunction

  task automatic line_bit(input logic v);
    Rx = v;
    repeat (BIT_CLK) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic stop);
    exp_t e;
    logic [7:0] mask;
    mask   = 8'((1 << nb) - 1);
    e.err  = ~stop;
    e.data = d & mask;
    exp_q.push_back(e);
    line_bit(1'b0);
    for (int i = 0; i < nb; i++) line_bit(d[i]);
    check("busy_run", 32'(Busy), 32'd1);
    line_bit(stop);
    check("busy_end", 32'(Busy), stop ? 32'd0 : 32'd1);
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_pulse;
    prev_pulse = 1'b0;
    forever begin
      @(negedge Clk);
      if (RxDone || FrameErr) begin
        check("excl", 32'(RxDone & FrameErr), 32'd0);
        check("pulse_w", 32'(prev_pulse), 32'd0);
        if (exp_q.size() == 0) begin
          check("spurious", 32'({RxDone, FrameErr}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("kind", 32'({FrameErr, RxDone}), e.err ? 32'd2 : 32'd1);
          check("data", 32'(RxData), 32'(e.data));
        end
      end
      prev_pulse = RxDone | FrameErr;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int nb;
    logic [7:0] d;

    repeat (5) @(negedge Clk);
    check("rst_data", 32'(RxData), 32'd0);
    check("rst_done", 32'(RxDone), 32'd0);
    check("rst_ferr", 32'(FrameErr), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    Rst_n = 1'b1;
    repeat (20) @(negedge Clk);

    NBits = 4'd8;
    send_frame(8'hA5, 8, 1'b1);
    line_bit(1'b1);

    NBits = 4'd5;
    send_frame(8'h1B, 5, 1'b1);
    line_bit(1'b1);

    // short low glitch must be rejected at the start-bit midpoint
    Rx = 1'b0;
    repeat (16) @(negedge Clk);
    Rx = 1'b1;
    check("glitch_busy", 32'(Busy), 32'd1);
    repeat (BIT_CLK) @(negedge Clk);
    check("glitch_idle", 32'(Busy), 32'd0);
    NBits = 4'd8;
    send_frame(8'h3C, 8, 1'b1);
    line_bit(1'b1);

    send_frame(8'h55, 8, 1'b0);
    repeat (3) line_bit(1'b0);
    check("break_busy", 32'(Busy), 32'd1);
    line_bit(1'b1);
    check("break_exit", 32'(Busy), 32'd0);
    send_frame(8'hF0, 8, 1'b1);
    line_bit(1'b1);

    send_frame(8'h01, 8, 1'b1);
    send_frame(8'h80, 8, 1'b1);
    line_bit(1'b1);

    // reset during data bit 3 of 0xFF aborts the frame
    line_bit(1'b0);
    for (int i = 0; i < 3; i++) line_bit(1'b1);
    repeat (BIT_CLK / 2) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(RxData), 32'd0);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_done", 32'(RxDone), 32'd0);
    check("mid_rst_ferr", 32'(FrameErr), 32'd0);
    repeat (4) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (6) line_bit(1'b1);
    send_frame(8'h42, 8, 1'b1);
    line_bit(1'b1);

    NBits = 4'd0;
    send_frame(8'h96, eff_bits(0), 1'b1);
    line_bit(1'b1);
    NBits = 4'd12;
    send_frame(8'h69, eff_bits(12), 1'b1);
    line_bit(1'b1);

    for (int k = 0; k < 4; k++) begin
      nb    = int'($urandom_range(5, 8));
      d     = 8'($urandom);
      NBits = 4'(nb);
      send_frame(d, nb, 1'b1);
      line_bit(1'b1);
    end

    repeat (2) line_bit(1'b1);
    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
